// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined add/sub with wrap or saturate modes, overflow flag and overflow counter
// Arithmetic happens in stage 1; later stages only delay result and ovf under a valid/ready handshake.
module pipe_addsub #(
  parameter int DATAWIDTH = 32,
  parameter int STAGES    = 2,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] result,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic [15:0]          ovf_count
);

  localparam int W = DATAWIDTH;

  logic                      adv;
  logic [STAGES-1:0]         vld_q;
  logic [STAGES-1:0][W-1:0]  res_q;
  logic [STAGES-1:0]         ovf_q;
  logic [15:0]               cnt_q;

  logic [W:0]   ext_a;
  logic [W:0]   ext_b;
  logic [W:0]   sum;
  logic [W-1:0] sat_val;
  logic         ovf_c;
  logic [W-1:0] res_c;

  assign out_valid = vld_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];
  assign ovf_count = cnt_q;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // One extra bit holds carry/borrow (unsigned) or the true sign (signed).
  always_comb begin
    ext_a   = {1'b0, a};
    ext_b   = {1'b0, b};
    sat_val = '0;
    ovf_c   = 1'b0;
    if (SIGNED != 0) begin
      ext_a = {a[W-1], a};
      ext_b = {b[W-1], b};
    end
    sum = mode[0] ? (ext_a - ext_b) : (ext_a + ext_b);
    if (SIGNED != 0) begin
      ovf_c   = sum[W] ^ sum[W-1];
      sat_val = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      ovf_c   = sum[W];
      sat_val = mode[0] ? '0 : '1;
    end
    res_c = (mode[1] && ovf_c) ? sat_val : sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      res_q <= '0;
      ovf_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        res_q[0] <= res_c;
        ovf_q[0] <= ovf_c;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

  // Clear wins over a coincident increment; the count sticks at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (ovf_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && ovf && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - directed bench for pipe_addsub, unsigned and signed instances side by side
module tb_pipe_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  mode;
  logic        ovf_clr;

  logic        in_ready_u, out_valid_u, ovf_u;
  logic [7:0]  result_u;
  logic [15:0] count_u;
  logic        in_ready_s, out_valid_s, ovf_s;
  logic [7:0]  result_s;
  logic [15:0] count_s;

  int total;
  int bad;
  int sent, got, cyc, delivered, guard;
  logic [7:0] va [6];
  logic [7:0] vb [6];
  logic [1:0] vm [6];
  logic [8:0] ve [6];

  pipe_addsub #(.DATAWIDTH(8), .STAGES(2), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_u), .out_ready(out_ready),
    .result(result_u), .ovf(ovf_u), .ovf_clr(ovf_clr), .ovf_count(count_u)
  );

  pipe_addsub #(.DATAWIDTH(8), .STAGES(2), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .ovf(ovf_s), .ovf_clr(ovf_clr), .ovf_count(count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unsigned reference: {ovf, result}
  function automatic logic [8:0] model_u(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
    int s;
    logic ov;
    logic [7:0] r;
    if (!m[0]) begin
      s  = int'(x) + int'(y);
      ov = (s > 255);
      r  = 8'(s & 255);
      if (m[1] && ov) r = 8'hFF;
    end else begin
      s  = int'(x) - int'(y);
      ov = (x < y);
      r  = 8'(s & 255);
      if (m[1] && ov) r = 8'h00;
    end
    return {ov, r};
  endfunction

  task automatic beat(input string tag, input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] m,
                      input logic [7:0] eu, input logic eo, input logic [7:0] es, input logic eso);
    @(negedge clk);
    a = xa; b = xb; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "/in_ready"}, 64'(in_ready_u), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; a = 8'h00; b = 8'h00; mode = 2'b00;
    @(negedge clk);
    chk({tag, "/early_valid"}, 64'(out_valid_u), 64'd0);
    @(negedge clk);
    chk({tag, "/out_valid"}, 64'(out_valid_u), 64'd1);
    chk({tag, "/res_u"}, 64'(result_u), 64'(eu));
    chk({tag, "/ovf_u"}, 64'(ovf_u), 64'(eo));
    chk({tag, "/out_valid_s"}, 64'(out_valid_s), 64'd1);
    chk({tag, "/res_s"}, 64'(result_s), 64'(es));
    chk({tag, "/ovf_s"}, 64'(ovf_s), 64'(eso));
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = '0; ovf_clr = 1'b0;
    #12;
    chk("rst/out_valid", 64'(out_valid_u), 64'd0);
    chk("rst/result", 64'(result_u), 64'd0);
    chk("rst/ovf", 64'(ovf_u), 64'd0);
    chk("rst/count", 64'(count_u), 64'd0);
    chk("rst/in_ready", 64'(in_ready_u), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;

    beat("usub_wrap", 8'h05, 8'h07, 2'b01, 8'hFE, 1'b1, 8'hFE, 1'b0);
    beat("uadd_wrap", 8'hF0, 8'h20, 2'b00, 8'h10, 1'b1, 8'h10, 1'b0);
    beat("uadd_sat",  8'hF0, 8'h20, 2'b10, 8'hFF, 1'b1, 8'h10, 1'b0);
    beat("usub_sat",  8'h05, 8'h07, 2'b11, 8'h00, 1'b1, 8'hFE, 1'b0);
    beat("usub_nov",  8'h10, 8'h01, 2'b11, 8'h0F, 1'b0, 8'h0F, 1'b0);
    @(negedge clk);
    chk("count_u_4", 64'(count_u), 64'd4);

    beat("sadd_sat",  8'h7F, 8'h01, 2'b10, 8'h80, 1'b0, 8'h7F, 1'b1);
    beat("ssub_sat",  8'h80, 8'h01, 2'b11, 8'h7F, 1'b0, 8'h80, 1'b1);
    beat("ssub_wrap", 8'h80, 8'h01, 2'b01, 8'h7F, 1'b0, 8'h7F, 1'b1);
    beat("sadd_neg",  8'h80, 8'hFF, 2'b10, 8'hFF, 1'b1, 8'h80, 1'b1);
    @(negedge clk);
    chk("count_u_5", 64'(count_u), 64'd5);
    chk("count_s_4", 64'(count_s), 64'd4);

    // Reset with two beats in flight
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'h01; mode = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    a = 8'hFE;
    @(posedge clk);
    #2 chk("inflight/out_valid", 64'(out_valid_u), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst/out_valid", 64'(out_valid_u), 64'd0);
    chk("arst/out_valid_s", 64'(out_valid_s), 64'd0);
    chk("arst/count", 64'(count_u), 64'd0);
    chk("arst/in_ready", 64'(in_ready_u), 64'd1);
    chk("arst/result", 64'(result_u), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst/no_stale", 64'(out_valid_u), 64'd0);
    end

    // Backpressure with a reference model
    for (int i = 0; i < 6; i++) begin
      va[i] = 8'($urandom_range(0, 255));
      vb[i] = 8'($urandom_range(0, 255));
      vm[i] = 2'($urandom_range(0, 3));
      ve[i] = model_u(va[i], vb[i], vm[i]);
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 6 && cyc < 100) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        a = va[sent]; b = vb[sent]; mode = vm[sent];
      end
      #1;
      if (cyc >= 2 && cyc <= 4) chk("bp/in_ready_low", 64'(in_ready_u), 64'd0);
      if (out_valid_u) begin
        chk("bp/result", 64'(result_u), 64'(ve[got][7:0]));
        chk("bp/ovf", 64'(ovf_u), 64'(ve[got][8]));
        if (out_ready) got++;
      end
      if (in_valid && in_ready_u) sent++;
      cyc++;
    end
    chk("bp/all_delivered", 64'(got), 64'd6);
    in_valid = 1'b0; out_ready = 1'b1;

    // Counter saturation and clear priority
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clr/count", 64'(count_u), 64'd0);
    a = 8'hFF; b = 8'h01; mode = 2'b00; in_valid = 1'b1;
    delivered = 0; guard = 0;
    while (delivered < 65535 && guard < 70000) begin
      @(negedge clk);
      if (out_valid_u) delivered++;
      guard++;
    end
    chk("sat/delivered", 64'(delivered), 64'd65535);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat/count_ffff", 64'(count_u), 64'hFFFF);
    chk("sat/extra_beat", 64'(out_valid_u & ovf_u), 64'd1);
    in_valid = 1'b1;
    @(negedge clk);
    chk("sat/count_hold", 64'(count_u), 64'hFFFF);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clrpri/ovf_beat", 64'(out_valid_u & ovf_u), 64'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clrpri/count", 64'(count_u), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter DATAWIDTH, default 32, SHALL set the operand and result width in bits (legal 2..64).
REQ-002 Parameter STAGES, default 2, SHALL set the pipeline depth in register stages (legal 1..8).
REQ-003 Parameter SIGNED, default 0, SHALL select the operand interpretation: 0 unsigned, 1 two's complement.
REQ-004 Ports SHALL be, clock and reset first:
 clk  in  1  sole clock; all state changes on rising edge
 rst  in  1  asynchronous, active-low reset
 in_valid  in  1  input beat present
 in_ready  out  1  block accepts input this cycle
 a  in  DATAWIDTH  operand A
 b  in  DATAWIDTH  operand B
 mode  in  2  00 add-wrap, 01 sub-wrap, 10 add-saturate, 11 sub-saturate
 out_valid  out  1  result beat present
 out_ready  in  1  downstream accepts result
 result  out  DATAWIDTH  arithmetic result
 ovf  out  1  overflow flag for the current result beat
 ovf_clr  in  1  synchronous clear of ovf_count
 ovf_count  out  16  count of delivered beats with ovf=1

Function
REQ-005 A beat SHALL be accepted on a clk edge where in_valid=1 and in_ready=1; a, b and mode SHALL be sampled only then.
REQ-006 The pipeline SHALL advance when adv = out_ready OR NOT out_valid; in_ready SHALL equal adv combinationally.
REQ-007 When adv=0, all stages SHALL hold their contents; no beat SHALL be lost, duplicated or reordered.
REQ-008 Unstalled latency SHALL be exactly STAGES cycles from the acceptance edge to out_valid=1 with that beat's result.
REQ-009 Empty stages SHALL be tracked by per-stage valid bits; bubbles SHALL propagate so back-to-back beats reach one result per cycle.
REQ-010 Arithmetic SHALL be computed in stage 1 at DATAWIDTH+1 bits; later stages SHALL only delay result and ovf.
REQ-011 Unsigned add: ovf = carry out of bit DATAWIDTH-1; wrap result = low DATAWIDTH bits; saturate result = all ones when ovf.
REQ-012 Unsigned sub: ovf = 1 when a < b; wrap result = (a - b) mod 2^DATAWIDTH; saturate result = 0 when ovf.
REQ-013 Signed add/sub: ovf = true two's-complement overflow (operand signs vs. result sign); saturate result = max positive if true sign positive, min negative otherwise.
REQ-014 ovf SHALL be reported identically in wrap and saturate modes; in saturate modes result SHALL equal the wrap result when ovf=0.
REQ-015 result and ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-016 ovf_count SHALL increment by 1 on each edge where out_valid=1, out_ready=1 and ovf=1, and SHALL saturate at 16'hFFFF.
REQ-017 ovf_clr=1 SHALL set ovf_count to 0 on the next edge; clear SHALL take priority over a simultaneous increment.
REQ-018 Values on result and ovf while out_valid=0 SHALL be don't-care for checking, but SHALL never be X after reset.

Reset
REQ-019 rst=0 SHALL immediately, independent of clk, force all stage valid bits, out_valid, result, ovf and ovf_count to 0.
REQ-020 in_ready SHALL read 1 during and after reset; beats in flight at reset assertion SHALL be discarded.
REQ-021 The first acceptance SHALL be possible on the first rising clk edge after rst returns to 1.

Verification (DATAWIDTH=8, STAGES=2 unless stated)
REQ-022 Reset: assert rst=0 mid-stream with 2 beats in flight -> out_valid=0, ovf_count=0, in_ready=1 immediately; no stale beat emerges after release.
REQ-023 Unsigned wrap: a=8'h05, b=8'h07, mode=01 -> result=8'hFE, ovf=1 exactly 2 cycles after acceptance; a=8'hF0, b=8'h20, mode=00 -> 8'h10, ovf=1.
REQ-024 Unsigned saturate: a=8'hF0, b=8'h20, mode=10 -> 8'hFF, ovf=1; a=8'h05, b=8'h07, mode=11 -> 8'h00, ovf=1; a=8'h10, b=8'h01, mode=11 -> 8'h0F, ovf=0.
REQ-025 Signed (SIGNED=1): 8'h7F + 8'h01 mode=10 -> 8'h7F, ovf=1; 8'h80 - 8'h01 mode=11 -> 8'h80, ovf=1; 8'h80 - 8'h01 mode=01 -> 8'h7F, ovf=1.
REQ-026 Backpressure: stream 6 random beats with in_valid=1, hold out_ready=0 for 5 cycles -> in_ready=0 once both stages full, outputs held stable, then all 6 results delivered in order against a reference model.
REQ-027 Counter: preload ovf_count to 16'hFFFF via 65535 ovf beats -> further ovf beats keep 16'hFFFF; ovf_clr=1 coincident with an ovf delivery -> ovf_count=0.
